// File: rtl/bcd_mod_counter_if.sv
// Bundles the counting controls, preset bus and status outputs of one
// bcd_mod_counter stage.
//   en, up_dn      : count tick qualifier and direction
//   load, load_val : synchronous BCD preset request and value
//   count          : current BCD value, digit 0 in [3:0]
//   co, load_err   : registered wrap strobe and rejected-preset strobe
//   lap, lap_val   : lap capture request and captured value (LAP_CAPTURE_EN only)
// The slave modport is the counter side; master is the controlling side.
interface bcd_mod_counter_if #(
  parameter int unsigned DIGITS = 2
);
  localparam int unsigned W = 4 * DIGITS;

  logic         en;
  logic         up_dn;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] count;
  logic         co;
  logic         load_err;
`ifdef LAP_CAPTURE_EN
  logic         lap;
  logic [W-1:0] lap_val;
`endif

  modport master (
    output en, up_dn, load, load_val,
`ifdef LAP_CAPTURE_EN
    output lap,
    input  lap_val,
`endif
    input  count, co, load_err
  );

  modport slave (
    input  en, up_dn, load, load_val,
`ifdef LAP_CAPTURE_EN
    input  lap,
    output lap_val,
`endif
    output count, co, load_err
  );
endinterface

// File: rtl/bcd_mod_counter.sv
// Multi-digit BCD counter with a configurable modulus, used as the common
// counting stage of the clock/stopwatch chain.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : bcd_mod_counter_if.slave (en, up_dn, load, load_val in;
//           count, co, load_err out; lap in / lap_val out when enabled)
// Priority per edge: load > en > hold. co and load_err are one-cycle
// strobes, high in the cycle count first shows the wrapped/cleared value.
// Optional feature: define LAP_CAPTURE_EN to add the lap capture register.
module bcd_mod_counter #(
  parameter int unsigned DIGITS  = 2,
  parameter int unsigned MODULUS = 100
) (
  input logic               clk,
  input logic               rst_n,
  bcd_mod_counter_if.slave  bus
);

  localparam int unsigned W = 4 * DIGITS;

  // Binary-to-BCD conversion, evaluated only at elaboration.
  function automatic logic [W-1:0] to_bcd(input int unsigned v);
    logic [W-1:0] r;
    int unsigned  t;
    r = '0;
    t = v;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Terminal value doubles as the preset validity threshold.
  localparam logic [W-1:0] TERM_BCD = to_bcd(MODULUS - 1);

  // Ripple BCD increment: a 9 rolls to 0 and carries on.
  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         carry;
    r     = v;
    carry = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Ripple BCD decrement: a 0 becomes 9 and borrows on.
  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         borrow;
    r      = v;
    borrow = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // With every digit <= 9, an unsigned compare of the BCD words matches
  // the decimal ordering, so no binary conversion is needed.
  function automatic logic bcd_valid(input logic [W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) ok = 1'b0;
    end
    return ok && (v <= TERM_BCD);
  endfunction

  logic [W-1:0] count_q, count_d;
  logic         co_q, co_d;
  logic         load_err_q, load_err_d;

  // Next-state: load > en > hold; strobes default low.
  always_comb begin
    count_d    = count_q;
    co_d       = 1'b0;
    load_err_d = 1'b0;
    if (bus.load) begin
      if (bcd_valid(bus.load_val)) begin
        count_d = bus.load_val;
      end else begin
        count_d    = '0;
        load_err_d = 1'b1;
      end
    end else if (bus.en) begin
      if (bus.up_dn) begin
        if (count_q == TERM_BCD) begin
          count_d = '0;
          co_d    = 1'b1;
        end else begin
          count_d = bcd_inc(count_q);
        end
      end else begin
        if (count_q == '0) begin
          count_d = TERM_BCD;
          co_d    = 1'b1;
        end else begin
          count_d = bcd_dec(count_q);
        end
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= '0;
      co_q       <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      co_q       <= co_d;
      load_err_q <= load_err_d;
    end
  end

  assign bus.count    = count_q;
  assign bus.co       = co_q;
  assign bus.load_err = load_err_q;

`ifdef LAP_CAPTURE_EN
  logic [W-1:0] lap_val_q, lap_val_d;

  // Captures the pre-update count, independent of load/en that cycle.
  always_comb begin
    lap_val_d = lap_val_q;
    if (bus.lap) lap_val_d = count_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lap_val_q <= '0;
    else        lap_val_q <= lap_val_d;
  end

  assign bus.lap_val = lap_val_q;
`endif

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Directed bench: a mod-60 stage cascaded into a mod-24 stage, plus a
// single-digit mod-2 stage for back-to-back wraps.
module tb_bcd_mod_counter;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  bcd_mod_counter_if #(.DIGITS(2)) sec_if ();
  bcd_mod_counter_if #(.DIGITS(2)) hr_if  ();
  bcd_mod_counter_if #(.DIGITS(1)) m2_if  ();

  bcd_mod_counter #(.DIGITS(2), .MODULUS(60)) u_sec (.clk(clk), .rst_n(rst_n), .bus(sec_if));
  bcd_mod_counter #(.DIGITS(2), .MODULUS(24)) u_hr  (.clk(clk), .rst_n(rst_n), .bus(hr_if));
  bcd_mod_counter #(.DIGITS(1), .MODULUS(2))  u_m2  (.clk(clk), .rst_n(rst_n), .bus(m2_if));

  assign hr_if.en = sec_if.co;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    sec_if.en = 1'b0; sec_if.up_dn = 1'b1; sec_if.load = 1'b0; sec_if.load_val = '0;
    hr_if.up_dn = 1'b1; hr_if.load = 1'b0; hr_if.load_val = '0;
    m2_if.en = 1'b0; m2_if.up_dn = 1'b1; m2_if.load = 1'b0; m2_if.load_val = '0;
`ifdef LAP_CAPTURE_EN
    sec_if.lap = 1'b0; hr_if.lap = 1'b0; m2_if.lap = 1'b0;
`endif
    #12;
    check_val("rst_count", 32'(sec_if.count), 32'h00);
    check_val("rst_co", 32'(sec_if.co), 32'h0);
    check_val("rst_err", 32'(sec_if.load_err), 32'h0);
`ifdef LAP_CAPTURE_EN
    check_val("rst_lap", 32'(sec_if.lap_val), 32'h00);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Up count through the mod-60 wrap.
    sec_if.en = 1'b1; sec_if.up_dn = 1'b1;
    repeat (59) tick();
    check_val("up59_count", 32'(sec_if.count), 32'h59);
    check_val("up59_co", 32'(sec_if.co), 32'h0);
    tick();
    check_val("wrap_count", 32'(sec_if.count), 32'h00);
    check_val("wrap_co", 32'(sec_if.co), 32'h1);
    sec_if.en = 1'b0;
    tick();
    check_val("hold_count", 32'(sec_if.count), 32'h00);
    check_val("hold_co", 32'(sec_if.co), 32'h0);

    // Down count through zero.
    sec_if.en = 1'b1; sec_if.up_dn = 1'b0;
    tick();
    check_val("dn_wrap_count", 32'(sec_if.count), 32'h59);
    check_val("dn_wrap_co", 32'(sec_if.co), 32'h1);
    tick();
    check_val("dn_count", 32'(sec_if.count), 32'h58);
    check_val("dn_co", 32'(sec_if.co), 32'h0);
    tick();
    check_val("dn_digit_stay", 32'(sec_if.count), 32'h57);
    sec_if.load = 1'b1; sec_if.load_val = 8'h50;
    tick();
    sec_if.load = 1'b0;
    tick();
    check_val("dn_borrow", 32'(sec_if.count), 32'h49);
    sec_if.en = 1'b0; sec_if.up_dn = 1'b1;

    // Preset validation.
    sec_if.load = 1'b1; sec_if.load_val = 8'h45;
    tick();
    check_val("ld45_count", 32'(sec_if.count), 32'h45);
    check_val("ld45_err", 32'(sec_if.load_err), 32'h0);
    sec_if.load_val = 8'h60;
    tick();
    check_val("ld60_count", 32'(sec_if.count), 32'h00);
    check_val("ld60_err", 32'(sec_if.load_err), 32'h1);
    sec_if.load_val = 8'h3A;
    tick();
    check_val("ld3A_count", 32'(sec_if.count), 32'h00);
    check_val("ld3A_err", 32'(sec_if.load_err), 32'h1);
    sec_if.load_val = 8'h59;
    tick();
    check_val("ld59_err", 32'(sec_if.load_err), 32'h0);
    check_val("ld59_count", 32'(sec_if.count), 32'h59);

    // Load beats en on the same edge, even at the terminal value.
    sec_if.en = 1'b1; sec_if.load_val = 8'h10;
    tick();
    check_val("ld_en_count", 32'(sec_if.count), 32'h10);
    check_val("ld_en_co", 32'(sec_if.co), 32'h0);
    sec_if.load = 1'b0; sec_if.en = 1'b0;
    tick();
    check_val("err_clear", 32'(sec_if.load_err), 32'h0);

    // Cascade 0x23:0x59 -> 0x00:0x00.
    sec_if.load = 1'b1; sec_if.load_val = 8'h59;
    hr_if.load = 1'b1; hr_if.load_val = 8'h23;
    tick();
    sec_if.load = 1'b0; hr_if.load = 1'b0;
    check_val("cas_hr_pre", 32'(hr_if.count), 32'h23);
    sec_if.en = 1'b1;
    tick();
    sec_if.en = 1'b0;
    check_val("cas_lo_count", 32'(sec_if.count), 32'h00);
    check_val("cas_lo_co", 32'(sec_if.co), 32'h1);
    check_val("cas_hr_wait", 32'(hr_if.count), 32'h23);
    tick();
    check_val("cas_hr_count", 32'(hr_if.count), 32'h00);
    check_val("cas_hr_co", 32'(hr_if.co), 32'h1);
    tick();
    check_val("cas_hr_co_drop", 32'(hr_if.co), 32'h0);
    hr_if.load = 1'b1; hr_if.load_val = 8'h24;
    tick();
    hr_if.load = 1'b0;
    check_val("hr_ld24_err", 32'(hr_if.load_err), 32'h1);

    // Asynchronous reset mid-count.
    sec_if.load = 1'b1; sec_if.load_val = 8'h36;
    tick();
    sec_if.load = 1'b0; sec_if.en = 1'b1;
    tick();
    check_val("pre_rst_count", 32'(sec_if.count), 32'h37);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("async_rst_count", 32'(sec_if.count), 32'h00);
    check_val("async_rst_co", 32'(sec_if.co), 32'h0);
    sec_if.en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

`ifdef LAP_CAPTURE_EN
    // Lap takes the pre-update count while en advances it.
    sec_if.load = 1'b1; sec_if.load_val = 8'h37;
    tick();
    sec_if.load = 1'b0; sec_if.en = 1'b1; sec_if.lap = 1'b1;
    tick();
    check_val("lap_val", 32'(sec_if.lap_val), 32'h37);
    check_val("lap_count", 32'(sec_if.count), 32'h38);
    sec_if.lap = 1'b0;
    tick();
    check_val("lap_hold", 32'(sec_if.lap_val), 32'h37);
    check_val("lap_count2", 32'(sec_if.count), 32'h39);
    sec_if.en = 1'b0;
`endif

    // Mod-2 single digit: wrap strobe on every other tick, both directions.
    m2_if.en = 1'b1; m2_if.up_dn = 1'b1;
    tick();
    check_val("m2_up1", 32'({m2_if.co, m2_if.count}), 32'h01);
    tick();
    check_val("m2_up2", 32'({m2_if.co, m2_if.count}), 32'h10);
    tick();
    check_val("m2_up3", 32'({m2_if.co, m2_if.count}), 32'h01);
    m2_if.up_dn = 1'b0;
    tick();
    check_val("m2_dn1", 32'({m2_if.co, m2_if.count}), 32'h00);
    tick();
    check_val("m2_dn2", 32'({m2_if.co, m2_if.count}), 32'h11);
    m2_if.en = 1'b0; m2_if.load = 1'b1; m2_if.load_val = 4'h2;
    tick();
    m2_if.load = 1'b0;
    check_val("m2_ld2", 32'({m2_if.load_err, m2_if.count}), 32'h10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bcd_mod_counter.md
Name: bcd_mod_counter

Overview:
- Parametrised multi-digit BCD counter with a configurable modulus, to serve as the common counting primitive for the clock/stopwatch chain (centiseconds, seconds, minutes, hours).
- Adds count enable, up/down counting, a synchronous validated preset and a registered wrap strobe for cascading.
- Successor to the fixed two-digit, mod-100 preset counter.

Parameters:
- DIGITS, 2, number of BCD digits (1..6); count width is 4*DIGITS.
- MODULUS, 100, count range is 0..MODULUS-1; legal range is 2..10^DIGITS.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  count tick, one-cycle qualifier from the upstream prescaler or the previous stage's co.
- up_dn  in  1  1 = count up, 0 = count down; sampled with en.
- load  in  1  synchronous preset request (time-set mode).
- load_val  in  4*DIGITS  BCD preset value; digit 0 in [3:0].
- count  out  4*DIGITS  current BCD value; digit 0 in [3:0].
- co  out  1  registered wrap strobe (carry on up, borrow on down).
- load_err  out  1  registered strobe: rejected preset.

Behaviour:
- Reset (async, rst_n low): count = 0, co = 0, load_err = 0. Release takes effect at the next clk edge.
- Priority per clk edge: load > en > hold.
- load = 1: if every digit of load_val is <= 9 and its value is < MODULUS, count <= load_val and load_err <= 0. Otherwise count <= 0 and load_err <= 1.
  - co <= 0 in either case; en is ignored that cycle.
- en = 1, up_dn = 1: if count == MODULUS-1, count <= 0 and co <= 1. Otherwise count <= count+1 in BCD and co <= 0.
  - BCD increment: a digit at 9 rolls to 0 and carries into the next digit.
- en = 1, up_dn = 0: if count == 0, count <= MODULUS-1 (in BCD) and co <= 1. Otherwise count <= count-1 in BCD and co <= 0.
  - BCD decrement: a digit at 0 becomes 9 and borrows from the next digit.
- en = 0, load = 0: count holds; co <= 0; load_err <= 0.
- co and load_err are single-cycle strobes, high in the cycle count first shows the wrapped or cleared value. Latency is 1 cycle from the en/load edge.
- Back-to-back en with a wrap on every tick (MODULUS = 2 alternating) keeps co high on each wrap cycle. No suppression.
- Terminal value MODULUS-1 and the validity threshold are elaboration-time BCD constants. No runtime division.
- count never holds a non-BCD digit or a value >= MODULUS, whatever the input sequence.
- up_dn changing between ticks is legal. The direction is taken only from the edge with en = 1.
- rst_n asserted mid-count or mid-load: outputs clear immediately. A load pending at that edge is lost.
- Cascading: the next stage's en = this stage's co. Ripple delay is one cycle per stage; this is accepted.

Optional Feature:
- Macro LAP_CAPTURE_EN.
- Defined: adds input lap (1 bit) and output lap_val (4*DIGITS, reset 0).
  - lap = 1 at a clk edge: lap_val <= the count value present before that edge's update, including when load or en act in the same cycle.
  - lap_val otherwise holds.
- Undefined: the lap and lap_val ports do not exist and there is no capture register. All other behaviour is identical.

Test Plan:
- DIGITS=2, MODULUS=60, reset then 59 en ticks (up) -> count = 0x59, co = 0. Next tick -> count = 0x00 and co = 1 for exactly one cycle.
- MODULUS=60, count = 0x00, one en tick with up_dn = 0 -> count = 0x59, co = 1. Next down tick -> 0x58, co = 0.
- MODULUS=60: load_val = 0x45 -> count = 0x45, load_err = 0. load_val = 0x60 -> count = 0x00, load_err = 1. load_val = 0x3A -> count = 0x00, load_err = 1.
- load = 1 and en = 1 on the same edge with count = 0x59, load_val = 0x10 -> count = 0x10, co = 0.
- DIGITS=2, MODULUS=24 cascaded after MODULUS=60, preset 0x23 and 0x59, one tick on the lower stage -> lower 0x00; next cycle upper 0x00 with upper co = 1.
- rst_n pulsed low asynchronously mid-count at 0x37 -> count = 0x00, co = 0 before the next clk edge. With LAP_CAPTURE_EN: lap at 0x37 with en -> lap_val = 0x37, count = 0x38.
